fastica_iter_sched: RTL and testbench
=====================================

FASTICA_ITER_SCHED -- requirements
Module: fastica_iter_sched

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 128, meaning samples per batch (2..256).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning sample address width (2^ADDR_W >= N_SAMPLES).
REQ-003 The block SHALL have parameter MAX_ITER, default 64, meaning fixed-point iterations allowed before failure.
REQ-004 The block SHALL have parameter TIMEOUT, default 4096, meaning per-stage cycle limit awaiting done.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (one per line):
- clk_fastica  in  1  sole clock, rising edge
- rst_fastica  in  1  synchronous active-high reset
- go_fastica  in  1  start pulse; ignored unless IDLE
- smp_valid  in  1  input sample present this cycle (LOAD)
- smp_wr  out  1  write strobe to sample memories Z1..Z4
- smp_addr  out  ADDR_W  sample memory address (write in LOAD, read in FAST/OUTPUT)
- start_symm / start_norm / start_fast / start_error  out  1 each  one-cycle stage start pulses
- done_symm / done_norm / done_fast / done_error  in  1 each  stage completion pulses
- is_converge  in  1  convergence flag, valid with done_error
- fast_en / mul_en  out  1 each  sample-stream enables to one-unit and output multiplier
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on batch completion
- fail  out  1  sticky failure flag
- fail_code  out  2  00 none, 01 stage timeout, 10 max iterations
- iter_cnt  out  8  completed iterations this batch

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, SYMM, NORM, FAST, ERROR, OUTPUT.
REQ-007 IDLE + go_fastica SHALL go to LOAD and clear smp_addr, iter_cnt, fail, fail_code.
REQ-008 In LOAD: smp_wr = smp_valid, combinationally; smp_addr increments per accepted sample; after the N_SAMPLES-th sample the FSM SHALL go to SYMM; no timeout applies in LOAD.
REQ-009 On entry to SYMM/NORM/FAST/ERROR, the matching start_* SHALL be high for exactly the first cycle in that state.
REQ-010 done_* SHALL be honoured only in its matching state and not in the start cycle; otherwise it is ignored.
REQ-011 Transitions: SYMM->NORM on done_symm; NORM->FAST on done_norm; FAST->ERROR on done_fast.
REQ-012 In FAST, from the cycle after start_fast, fast_en SHALL be high for exactly N_SAMPLES cycles, with smp_addr = 0..N_SAMPLES-1 in successive cycles; done_fast is honoured only after the stream ends.
REQ-013 On done_error with is_converge=1, the FSM SHALL go to OUTPUT.
REQ-014 On done_error with is_converge=0, iter_cnt SHALL increment; if the new value equals MAX_ITER, the FSM SHALL go to IDLE with fail=1 and fail_code=10; otherwise it SHALL go to SYMM.
REQ-015 In OUTPUT, mul_en SHALL be high for N_SAMPLES cycles with smp_addr 0..N_SAMPLES-1; the last cycle SHALL be followed by a done pulse and IDLE.
REQ-016 Timeout: a per-stage counter SHALL clear on stage entry; if TIMEOUT cycles pass without the honoured done, the FSM SHALL go to IDLE with fail=1 and fail_code=01.
REQ-017 fail/fail_code SHALL hold until the next accepted go_fastica or reset; done and fail SHALL never both be asserted.
REQ-018 go_fastica while busy SHALL have no effect.
REQ-019 iter_cnt SHALL saturate at 255 (MAX_ITER <= 255 is a legal-parameter rule).

Reset
REQ-020 rst_fastica SHALL, at the next clock edge, force IDLE from any state, including mid-stage and mid-stream.
REQ-021 rst_fastica SHALL drive every output to 0 (smp_addr=0, iter_cnt=0, fail_code=00); no start_* pulse is emitted.

Structure
REQ-022 Package fastica_pkg SHALL hold the state enum, fail_code constants, and the default N_SAMPLES.
REQ-023 Sub-module fastica_stage_timer (clear, count, expire at TIMEOUT) SHALL implement REQ-016.

Verification (N_SAMPLES=4, MAX_ITER=3, TIMEOUT=16)
REQ-024 Nominal: go, 4 smp_valid, every done 3 cycles after its start, is_converge=1 on first error -> smp_wr addrs 0..3, fast_en 4 cycles, mul_en 4 cycles, done=1, iter_cnt=0.
REQ-025 Non-converge: is_converge=0 always -> three SYMM..ERROR loops, then fail=1, fail_code=10, iter_cnt=3, no done.
REQ-026 Timeout: withhold done_norm -> fail_code=01 exactly 16 cycles after NORM entry, busy=0.
REQ-027 Spurious handshakes: done_error during FAST, done_symm in the start_symm cycle, go_fastica mid-LOAD -> all ignored, sequence unchanged.
REQ-028 Reset mid-FAST stream (addr=2) -> next cycle: IDLE, all outputs 0; fresh go restarts at LOAD with addr 0.

Source files
------------

// File: rtl/fastica_pkg.sv
// fastica_pkg
// Shared definitions for the FastICA iteration scheduler:
//   - fastica_state_e : scheduler FSM states (IDLE encodes as 0)
//   - FAIL_*          : fail_code values
//   - DEF_N_SAMPLES   : default batch length
package fastica_pkg;

    localparam int DEF_N_SAMPLES = 128;

    localparam logic [1:0] FAIL_NONE     = 2'b00;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAIL_MAX_ITER = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SYMM   = 3'd2,
        ST_NORM   = 3'd3,
        ST_FAST   = 3'd4,
        ST_ERROR  = 3'd5,
        ST_OUTPUT = 3'd6
    } fastica_state_e;

endpackage

// File: rtl/fastica_stage_timer.sv
// fastica_stage_timer
// Per-stage watchdog. The count restarts whenever a stage is entered and
// advances each cycle the stage is being timed. expired is high during the
// TIMEOUT-th timed cycle, so the scheduler leaves the stage on the edge that
// ends it: exactly TIMEOUT cycles after stage entry.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   clear   in  restart count (stage transition this cycle)
//   en      in  current state is a timed stage
//   expired out TIMEOUT cycles spent in the stage without leaving it
module fastica_stage_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fastica_iter_sched.sv
// fastica_iter_sched
// Top-level scheduler for a FastICA batch: loads N_SAMPLES samples, then
// loops SYMM -> NORM -> FAST -> ERROR until the error unit reports
// convergence (then streams the result in OUTPUT) or MAX_ITER iterations
// elapse. Each compute stage is guarded by a watchdog.
//
// Stage handshake: on entry to SYMM/NORM/FAST/ERROR the matching start_*
// is high for exactly the first cycle in that state. The matching done_*
// is a single-cycle pulse that is only honoured while in that state and
// after the start cycle (in FAST additionally after the sample stream has
// ended); any other done_* pulse is ignored. is_converge is sampled only
// together with an honoured done_error.
//
// Ports:
//   clk_fastica, rst_fastica  clock / synchronous active-high reset
//   go_fastica                start pulse, accepted only in IDLE
//   smp_valid                 sample present (LOAD)
//   smp_wr, smp_addr          sample memory write strobe / address
//   start_*, done_*           per-stage handshake (see above)
//   is_converge               convergence flag, with done_error
//   fast_en, mul_en           sample-stream enables (FAST / OUTPUT)
//   busy, done, fail          status; done is a one-cycle pulse
//   fail_code, iter_cnt       failure reason / completed iterations
//   fsm_state                 current FSM state, for observation
module fastica_iter_sched
    import fastica_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int ADDR_W    = 8,
    parameter int MAX_ITER  = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk_fastica,
    input  logic              rst_fastica,
    input  logic              go_fastica,
    input  logic              smp_valid,
    output logic              smp_wr,
    output logic [ADDR_W-1:0] smp_addr,
    output logic              start_symm,
    output logic              start_norm,
    output logic              start_fast,
    output logic              start_error,
    input  logic              done_symm,
    input  logic              done_norm,
    input  logic              done_fast,
    input  logic              done_error,
    input  logic              is_converge,
    output logic              fast_en,
    output logic              mul_en,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [7:0]        iter_cnt,
    output fastica_state_e    fsm_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
    localparam logic [7:0]        ITER_LIM  = 8'(MAX_ITER);

    fastica_state_e    state_q, state_d;
    logic              entry_q;       // first cycle in the current state
    logic              strm_done_q, strm_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        iter_q, iter_d, iter_inc;
    logic              fail_q, fail_d;
    logic [1:0]        code_q, code_d;
    logic              done_q, done_d;
    logic              timed;
    logic              tmr_clear;
    logic              tmr_expired;

    fastica_stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk_fastica),
        .rst     (rst_fastica),
        .clear   (tmr_clear),
        .en      (timed),
        .expired (tmr_expired)
    );

    // Saturating increment keeps iter_cnt at 255 for any legal MAX_ITER.
    assign iter_inc = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;

    always_ff @(posedge clk_fastica) begin
        if (rst_fastica) begin
            state_q     <= ST_IDLE;
            entry_q     <= 1'b0;
            strm_done_q <= 1'b0;
            addr_q      <= '0;
            iter_q      <= '0;
            fail_q      <= 1'b0;
            code_q      <= FAIL_NONE;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= (state_d != state_q);
            strm_done_q <= strm_done_d;
            addr_q      <= addr_d;
            iter_q      <= iter_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        strm_done_d = strm_done_q;
        addr_d      = addr_q;
        iter_d      = iter_q;
        fail_d      = fail_q;
        code_d      = code_q;
        done_d      = 1'b0;
        smp_wr      = 1'b0;
        start_symm  = 1'b0;
        start_norm  = 1'b0;
        start_fast  = 1'b0;
        start_error = 1'b0;
        fast_en     = 1'b0;
        mul_en      = 1'b0;
        timed       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_fastica) begin
                    state_d = ST_LOAD;
                    iter_d  = '0;
                    fail_d  = 1'b0;
                    code_d  = FAIL_NONE;
                end
            end
            ST_LOAD: begin
                smp_wr = smp_valid;
                if (smp_valid) begin
                    if (addr_q == LAST_ADDR) state_d = ST_SYMM;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_SYMM: begin
                timed      = 1'b1;
                start_symm = entry_q;
                if (!entry_q && done_symm) state_d = ST_NORM;
            end
            ST_NORM: begin
                timed      = 1'b1;
                start_norm = entry_q;
                if (!entry_q && done_norm) state_d = ST_FAST;
            end
            ST_FAST: begin
                timed      = 1'b1;
                start_fast = entry_q;
                // Stream runs from the cycle after start_fast until the
                // last address has been presented.
                fast_en    = !entry_q && !strm_done_q;
                if (fast_en) begin
                    if (addr_q == LAST_ADDR) strm_done_d = 1'b1;
                    else                     addr_d      = addr_q + 1'b1;
                end
                if (strm_done_q && done_fast) state_d = ST_ERROR;
            end
            ST_ERROR: begin
                timed       = 1'b1;
                start_error = entry_q;
                if (!entry_q && done_error) begin
                    if (is_converge) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        iter_d = iter_inc;
                        if (iter_inc == ITER_LIM) begin
                            state_d = ST_IDLE;
                            fail_d  = 1'b1;
                            code_d  = FAIL_MAX_ITER;
                        end else begin
                            state_d = ST_SYMM;
                        end
                    end
                end
            end
            ST_OUTPUT: begin
                mul_en = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A done arriving in the final allowed cycle still wins over the
        // watchdog; expiry only applies when the stage would otherwise stay.
        if (timed && tmr_expired && (state_d == state_q)) begin
            state_d = ST_IDLE;
            fail_d  = 1'b1;
            code_d  = FAIL_TIMEOUT;
        end

        // Every state starts with a fresh address and stream status.
        if (state_d != state_q) begin
            addr_d      = '0;
            strm_done_d = 1'b0;
        end
    end

    assign tmr_clear = (state_d != state_q);
    assign smp_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign iter_cnt  = iter_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fastica_iter_sched.sv
// tb_fastica_iter_sched
// Directed scenarios for the FastICA scheduler with N_SAMPLES=4,
// MAX_ITER=3, TIMEOUT=16. A responder answers each stage start with a done
// pulse; a monitor turns visible DUT activity into event words and compares
// them against the expected-event queue filled by the driver.
module tb_fastica_iter_sched;
    import fastica_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int MI = 3;
    localparam int TO = 16;

    localparam int EV_WR   = 1;
    localparam int EV_FEN  = 2;
    localparam int EV_MUL  = 3;
    localparam int EV_SS   = 4;
    localparam int EV_SN   = 5;
    localparam int EV_SF   = 6;
    localparam int EV_SE   = 7;
    localparam int EV_DONE = 8;
    localparam int EV_FAIL = 9;

    logic           clk;
    logic           rst;
    logic           go;
    logic           smp_valid;
    logic           smp_wr;
    logic [AW-1:0]  smp_addr;
    logic           start_symm, start_norm, start_fast, start_error;
    logic           done_symm, done_norm, done_fast, done_error;
    logic           is_converge;
    logic           fast_en, mul_en, busy, done, fail;
    logic [1:0]     fail_code;
    logic [7:0]     iter_cnt;
    fastica_state_e fsm_state;

    fastica_iter_sched #(
        .N_SAMPLES (N),
        .ADDR_W    (AW),
        .MAX_ITER  (MI),
        .TIMEOUT   (TO)
    ) dut (
        .clk_fastica (clk),
        .rst_fastica (rst),
        .go_fastica  (go),
        .smp_valid   (smp_valid),
        .smp_wr      (smp_wr),
        .smp_addr    (smp_addr),
        .start_symm  (start_symm),
        .start_norm  (start_norm),
        .start_fast  (start_fast),
        .start_error (start_error),
        .done_symm   (done_symm),
        .done_norm   (done_norm),
        .done_fast   (done_fast),
        .done_error  (done_error),
        .is_converge (is_converge),
        .fast_en     (fast_en),
        .mul_en      (mul_en),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .fail_code   (fail_code),
        .iter_cnt    (iter_cnt),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] ev(int kind, int data);
        return {4'(kind), 12'(data)};
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic compare_ev(input logic [15:0] got);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got %h expected none (queue empty)", got);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                bad++;
                $display("FAIL event: got %h expected %h", got, e);
            end
        end
    endtask

    // Monitor: one event per visible activity, sampled on the falling edge.
    logic fail_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (smp_wr)      compare_ev(ev(EV_WR, int'(smp_addr)));
            if (start_symm)  compare_ev(ev(EV_SS, 0));
            if (start_norm)  compare_ev(ev(EV_SN, 0));
            if (start_fast)  compare_ev(ev(EV_SF, 0));
            if (start_error) compare_ev(ev(EV_SE, 0));
            if (fast_en)     compare_ev(ev(EV_FEN, int'(smp_addr)));
            if (mul_en)      compare_ev(ev(EV_MUL, int'(smp_addr)));
            if (done)        compare_ev(ev(EV_DONE, (int'(fail) << 8) | int'(iter_cnt)));
            if (fail && !fail_prev)
                compare_ev(ev(EV_FAIL, (int'(fail_code) << 8) | int'(iter_cnt)));
        end
        fail_prev = fail;
    end

    // ---------------- stage responder ----------------
    logic converge  = 1'b1;
    logic hold_norm = 1'b0;
    logic inj_symm  = 1'b0;
    logic inj_err   = 1'b0;
    int   norm_cyc  = 0;

    initial begin
        int c_s, c_n, c_f, c_e;
        c_s = 0; c_n = 0; c_f = 0; c_e = 0;
        done_symm = 0; done_norm = 0; done_fast = 0; done_error = 0;
        is_converge = 0;
        forever begin
            @(posedge clk); #1;
            done_symm = 0; done_norm = 0; done_fast = 0; done_error = 0;
            is_converge = converge;
            if (rst) begin
                c_s = 0; c_n = 0; c_f = 0; c_e = 0;
            end else begin
                if (c_s > 0) begin c_s--; if (c_s == 0) done_symm  = 1; end
                if (c_n > 0) begin c_n--; if (c_n == 0) done_norm  = 1; end
                if (c_f > 0) begin c_f--; if (c_f == 0) done_fast  = 1; end
                if (c_e > 0) begin c_e--; if (c_e == 0) done_error = 1; end
                if (start_symm) begin
                    c_s = 3;
                    if (inj_symm) done_symm = 1;
                end
                if (start_norm) begin
                    norm_cyc = cyc_n;
                    if (!hold_norm) c_n = 3;
                end
                // done_fast only after the stream: 3 cycles after last address
                if (fast_en && int'(smp_addr) == N - 1) c_f = 3;
                if (start_error) c_e = 3;
                if (inj_err && fast_en && smp_addr == 8'd1) done_error = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic push_load();
        for (int a = 0; a < N; a++) exp_q.push_back(ev(EV_WR, a));
    endtask

    task automatic push_loop();
        exp_q.push_back(ev(EV_SS, 0));
        exp_q.push_back(ev(EV_SN, 0));
        exp_q.push_back(ev(EV_SF, 0));
        for (int a = 0; a < N; a++) exp_q.push_back(ev(EV_FEN, a));
        exp_q.push_back(ev(EV_SE, 0));
    endtask

    task automatic push_out(input int iters);
        for (int a = 0; a < N; a++) exp_q.push_back(ev(EV_MUL, a));
        exp_q.push_back(ev(EV_DONE, iters));
    endtask

    task automatic start_batch(input bit gap, input bit mid_go);
        go = 1; cyc(); go = 0;
        for (int i = 0; i < N; i++) begin
            if (gap && i == 2) begin smp_valid = 0; cyc(); end
            smp_valid = 1;
            if (mid_go && i == 1) go = 1;
            cyc();
            go = 0;
            smp_valid = 0;
        end
    endtask

    task automatic wait_end(input string name);
        int k;
        k = 0;
        while (!(done || fail) && k < 600) begin cyc(); k++; end
        if (k >= 600) check({name, "_end_timeout"}, 0, 1);
    endtask

    task automatic drain(input string name);
        repeat (3) cyc();
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic nominal_checks(input string name);
        check({name, "_done"}, int'(done), 1);
        check({name, "_fail"}, int'(fail), 0);
        check({name, "_iter"}, int'(iter_cnt), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int k;
        rst = 1; go = 0; smp_valid = 0;
        repeat (3) cyc();
        check("rst_state", int'(fsm_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(smp_addr), 0);
        check("rst_outs", int'({smp_wr, start_symm, start_norm, start_fast, start_error,
                                fast_en, mul_en, done, fail, fail_code, iter_cnt}), 0);
        rst = 0;
        cyc();

        // Nominal: converge on first error check.
        converge = 1;
        push_load(); push_loop(); push_out(0);
        start_batch(0, 0);
        wait_end("nom");
        nominal_checks("nom");
        drain("nom");

        // Never converges: three iterations then max-iteration failure.
        converge = 0;
        push_load();
        for (int i = 0; i < MI; i++) push_loop();
        exp_q.push_back(ev(EV_FAIL, (2 << 8) | MI));
        start_batch(0, 0);
        wait_end("iter");
        check("iter_fail", int'(fail), 1);
        check("iter_code", int'(fail_code), 2);
        check("iter_cnt", int'(iter_cnt), MI);
        check("iter_done", int'(done), 0);
        drain("iter");
        check("iter_fail_sticky", int'(fail), 1);

        // Stage timeout: done_norm withheld.
        converge = 1; hold_norm = 1;
        push_load();
        exp_q.push_back(ev(EV_SS, 0));
        exp_q.push_back(ev(EV_SN, 0));
        exp_q.push_back(ev(EV_FAIL, (1 << 8) | 0));
        start_batch(0, 0);
        wait_end("tmo");
        check("tmo_delay", cyc_n - norm_cyc, TO);
        check("tmo_code", int'(fail_code), 1);
        check("tmo_busy", int'(busy), 0);
        hold_norm = 0;
        drain("tmo");

        // Spurious handshakes: go mid-LOAD, done_symm in start cycle,
        // done_error during FAST. Sequence must match nominal.
        inj_symm = 1; inj_err = 1;
        push_load(); push_loop(); push_out(0);
        start_batch(1, 1);
        wait_end("spur");
        nominal_checks("spur");
        check("spur_code_cleared", int'(fail_code), 0);
        inj_symm = 0; inj_err = 0;
        drain("spur");

        // Reset in the middle of the FAST stream at address 2.
        push_load();
        exp_q.push_back(ev(EV_SS, 0));
        exp_q.push_back(ev(EV_SN, 0));
        exp_q.push_back(ev(EV_SF, 0));
        for (int a = 0; a < 3; a++) exp_q.push_back(ev(EV_FEN, a));
        start_batch(0, 0);
        k = 0;
        while (!(fast_en && smp_addr == 8'd2) && k < 200) begin cyc(); k++; end
        if (k >= 200) check("rstmid_reach_addr2", 0, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        cyc();
        check("rstmid_state", int'(fsm_state), 0);
        check("rstmid_addr", int'(smp_addr), 0);
        check("rstmid_outs", int'({smp_wr, start_symm, start_norm, start_fast, start_error,
                                   fast_en, mul_en, busy, done, fail, fail_code, iter_cnt}), 0);
        rst = 0;
        cyc();
        check("rstmid_queue_left", exp_q.size(), 0);
        push_load(); push_loop(); push_out(0);
        start_batch(0, 0);
        wait_end("restart");
        nominal_checks("restart");
        drain("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
